// File: rtl/circuito_jogo_param.sv
// Sequence memory game: the player repeats a growing one-hot LED sequence on the buttons.
// Classic mode waits for presses only; show mode first plays the sequence back on the LEDs.
module circuito_jogo_param #(
  parameter int NBOTOES        = 4,
  parameter int NRODADAS       = 16,
  parameter int TIMEOUT_CICLOS = 3000,
  parameter int MOSTRA_CICLOS  = 50,
  localparam int RW = (NRODADAS > 1) ? $clog2(NRODADAS) : 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               jogar,
  input  logic               modo,
  input  logic [NBOTOES-1:0] botoes,
  output logic [NBOTOES-1:0] leds,
  output logic               ganhou,
  output logic               perdeu,
  output logic               pronto,
  output logic [RW-1:0]      db_rodada,
  output logic [3:0]         db_estado,
  output logic               db_timeout
);

  localparam int TW = (TIMEOUT_CICLOS > 1) ? $clog2(TIMEOUT_CICLOS) : 1;
  localparam int MW = (MOSTRA_CICLOS > 1) ? $clog2(MOSTRA_CICLOS) : 1;
  localparam logic [RW-1:0] ULTIMA_RODADA = RW'(NRODADAS - 1);
  localparam logic [TW-1:0] TIMEOUT_MAX   = TW'(TIMEOUT_CICLOS - 1);
  localparam logic [MW-1:0] MOSTRA_MAX    = MW'(MOSTRA_CICLOS - 1);

  typedef enum logic [3:0] {
    INICIAL        = 4'd0,
    PREPARA        = 4'd1,
    MOSTRA         = 4'd2,
    ESPERA         = 4'd3,
    REGISTRA       = 4'd4,
    COMPARA        = 4'd5,
    PROXIMA_JOGADA = 4'd6,
    PROXIMA_RODADA = 4'd7,
    FIM_GANHOU     = 4'd8,
    FIM_PERDEU     = 4'd9
  } estado_t;

  estado_t            estado_reg, estado_next;
  logic               modo_reg, modo_next;
  logic [RW-1:0]      rodada_reg, rodada_next;
  logic [RW-1:0]      jogada_reg, jogada_next;
  logic [RW-1:0]      mostra_idx_reg, mostra_idx_next;
  logic [MW-1:0]      mostra_cnt_reg, mostra_cnt_next;
  logic               mostra_apagado_reg, mostra_apagado_next;
  logic [TW-1:0]      timeout_cnt_reg, timeout_cnt_next;
  logic               db_timeout_reg, db_timeout_next;
  logic [NBOTOES-1:0] botoes_prev_reg;
  logic [NBOTOES-1:0] botoes_lat_reg, botoes_lat_next;
  logic               jogada_det;

  // Sequence entry k lights button (k mod NBOTOES)
  function automatic logic [NBOTOES-1:0] entry_of(input logic [RW-1:0] idx);
    entry_of = NBOTOES'(1) << (int'(idx) % NBOTOES);
  endfunction

  // Rising edge of "any button": held buttons, or ones held on entering ESPERA, never retrigger
  assign jogada_det = (botoes != '0) && (botoes_prev_reg == '0);

  always_ff @(posedge clock) begin
    if (reset) begin
      estado_reg         <= INICIAL;
      modo_reg           <= 1'b0;
      rodada_reg         <= '0;
      jogada_reg         <= '0;
      mostra_idx_reg     <= '0;
      mostra_cnt_reg     <= '0;
      mostra_apagado_reg <= 1'b0;
      timeout_cnt_reg    <= '0;
      db_timeout_reg     <= 1'b0;
      botoes_prev_reg    <= '0;
      botoes_lat_reg     <= '0;
    end else begin
      estado_reg         <= estado_next;
      modo_reg           <= modo_next;
      rodada_reg         <= rodada_next;
      jogada_reg         <= jogada_next;
      mostra_idx_reg     <= mostra_idx_next;
      mostra_cnt_reg     <= mostra_cnt_next;
      mostra_apagado_reg <= mostra_apagado_next;
      timeout_cnt_reg    <= timeout_cnt_next;
      db_timeout_reg     <= db_timeout_next;
      botoes_prev_reg    <= botoes;
      botoes_lat_reg     <= botoes_lat_next;
    end
  end

  always_comb begin
    estado_next         = estado_reg;
    modo_next           = modo_reg;
    rodada_next         = rodada_reg;
    jogada_next         = jogada_reg;
    mostra_idx_next     = mostra_idx_reg;
    mostra_cnt_next     = mostra_cnt_reg;
    mostra_apagado_next = mostra_apagado_reg;
    timeout_cnt_next    = timeout_cnt_reg;
    db_timeout_next     = db_timeout_reg;
    botoes_lat_next     = botoes_lat_reg;

    case (estado_reg)
      INICIAL: begin
        if (jogar) begin
          estado_next = PREPARA;
          modo_next   = modo;
        end
      end
      PREPARA: begin
        rodada_next      = '0;
        jogada_next      = '0;
        timeout_cnt_next = '0;
        db_timeout_next  = 1'b0;
        estado_next      = modo_reg ? MOSTRA : ESPERA;
      end
      MOSTRA: begin
        jogada_next = '0;
        // Each entry: MOSTRA_CICLOS cycles lit, then MOSTRA_CICLOS cycles dark
        if (mostra_cnt_reg == MOSTRA_MAX) begin
          mostra_cnt_next = '0;
          if (!mostra_apagado_reg) begin
            mostra_apagado_next = 1'b1;
          end else if (mostra_idx_reg == rodada_reg) begin
            estado_next = ESPERA;
          end else begin
            mostra_idx_next     = mostra_idx_reg + 1'b1;
            mostra_apagado_next = 1'b0;
          end
        end else begin
          mostra_cnt_next = mostra_cnt_reg + 1'b1;
        end
      end
      ESPERA: begin
        if (jogada_det) begin
          estado_next = REGISTRA;
        end else if (timeout_cnt_reg == TIMEOUT_MAX) begin
          estado_next     = FIM_PERDEU;
          db_timeout_next = 1'b1;
        end else begin
          timeout_cnt_next = timeout_cnt_reg + 1'b1;
        end
      end
      REGISTRA: begin
        botoes_lat_next = botoes;
        estado_next     = COMPARA;
      end
      COMPARA: begin
        if (botoes_lat_reg != entry_of(jogada_reg)) begin
          estado_next = FIM_PERDEU;
        end else if (jogada_reg < rodada_reg) begin
          estado_next = PROXIMA_JOGADA;
        end else if (rodada_reg == ULTIMA_RODADA) begin
          estado_next = FIM_GANHOU;
        end else begin
          estado_next = PROXIMA_RODADA;
        end
      end
      PROXIMA_JOGADA: begin
        jogada_next = jogada_reg + 1'b1;
        estado_next = ESPERA;
      end
      PROXIMA_RODADA: begin
        rodada_next = rodada_reg + 1'b1;
        jogada_next = '0;
        estado_next = modo_reg ? MOSTRA : ESPERA;
      end
      FIM_GANHOU, FIM_PERDEU: begin
        if (jogar) begin
          estado_next = PREPARA;
          modo_next   = modo;
        end
      end
      default: estado_next = INICIAL;
    endcase

    // Every fresh entry into ESPERA gets a full timeout window
    if (estado_next == ESPERA && estado_reg != ESPERA) begin
      timeout_cnt_next = '0;
    end
    if (estado_reg != MOSTRA) begin
      mostra_idx_next     = '0;
      mostra_cnt_next     = '0;
      mostra_apagado_next = 1'b0;
    end
  end

  always_comb begin
    leds = '0;
    if (estado_reg == ESPERA) begin
      leds = botoes;
    end else if (estado_reg == MOSTRA && !mostra_apagado_reg) begin
      leds = entry_of(mostra_idx_reg);
    end
  end

  assign ganhou     = (estado_reg == FIM_GANHOU);
  assign perdeu     = (estado_reg == FIM_PERDEU);
  assign pronto     = ganhou || perdeu;
  assign db_rodada  = rodada_reg;
  assign db_estado  = estado_reg;
  assign db_timeout = db_timeout_reg;

endmodule

// File: tb/tb_circuito_jogo_param.sv
// Directed bench for circuito_jogo_param: win, timeout, wrong press, multi-bit press,
// show-mode LED timing, reset mid-game and restart after a loss.
module tb_circuito_jogo_param;

  logic       clock;
  logic       reset;
  logic       jogar;
  logic       modo;
  logic [3:0] botoes;
  logic [3:0] leds;
  logic       ganhou;
  logic       perdeu;
  logic       pronto;
  logic [3:0] db_rodada;
  logic [3:0] db_estado;
  logic       db_timeout;

  int n_checks = 0;
  int n_fail   = 0;

  circuito_jogo_param #(
    .NBOTOES(4),
    .NRODADAS(16),
    .TIMEOUT_CICLOS(3000),
    .MOSTRA_CICLOS(4)
  ) dut (
    .clock(clock),
    .reset(reset),
    .jogar(jogar),
    .modo(modo),
    .botoes(botoes),
    .leds(leds),
    .ganhou(ganhou),
    .perdeu(perdeu),
    .pronto(pronto),
    .db_rodada(db_rodada),
    .db_estado(db_estado),
    .db_timeout(db_timeout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic press(input logic [3:0] v);
    $display("press rodada=%0d botoes=%b estado=%0d", db_rodada, v, db_estado);
    botoes = v;
    repeat (5) tick();
    botoes = 4'b0000;
    repeat (5) tick();
  endtask

  task automatic play_round(input int r);
    for (int j = 0; j <= r; j++) press(4'(1 << (j % 4)));
  endtask

  task automatic restart(input logic m);
    modo  = m;
    jogar = 1'b1;
    tick();
    jogar = 1'b0;
    tick();
  endtask

  task automatic wait_estado(input logic [3:0] code, input int max_cycles);
    int k;
    k = 0;
    while (db_estado !== code && k < max_cycles) begin
      tick();
      k++;
    end
    check_eq("wait_estado", 32'(db_estado), 32'(code));
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_estado"}, 32'(db_estado), 0);
    check_eq({tag, "_leds"}, 32'(leds), 0);
    check_eq({tag, "_ganhou"}, 32'(ganhou), 0);
    check_eq({tag, "_perdeu"}, 32'(perdeu), 0);
    check_eq({tag, "_pronto"}, 32'(pronto), 0);
    check_eq({tag, "_rodada"}, 32'(db_rodada), 0);
    check_eq({tag, "_timeout"}, 32'(db_timeout), 0);
  endtask

  initial begin
    reset  = 1'b1;
    jogar  = 1'b1;
    modo   = 1'b0;
    botoes = 4'b0000;
    tick();
    tick();
    check_idle("rst");
    reset = 1'b0;

    // Full classic game; round 1 also checks that a long hold counts once
    repeat (5) tick();
    jogar = 1'b0;
    check_eq("g1_start_estado", 32'(db_estado), 3);
    for (int r = 0; r < 16; r++) begin
      check_eq("g1_rodada", 32'(db_rodada), 32'(r));
      if (r == 1) begin
        botoes = 4'b0001;
        repeat (20) tick();
        check_eq("hold_perdeu", 32'(perdeu), 0);
        check_eq("hold_estado", 32'(db_estado), 3);
        botoes = 4'b0000;
        repeat (5) tick();
        press(4'b0010);
      end else begin
        play_round(r);
      end
    end
    check_eq("win_ganhou", 32'(ganhou), 1);
    check_eq("win_pronto", 32'(pronto), 1);
    check_eq("win_perdeu", 32'(perdeu), 0);
    check_eq("win_rodada", 32'(db_rodada), 15);
    check_eq("win_estado", 32'(db_estado), 8);

    // Timeout at round 3, jogada 1
    restart(1'b0);
    check_eq("rs1_ganhou", 32'(ganhou), 0);
    check_eq("rs1_rodada", 32'(db_rodada), 0);
    check_eq("rs1_estado", 32'(db_estado), 3);
    for (int r = 0; r < 3; r++) play_round(r);
    press(4'b0001);
    repeat (2993) tick();
    check_eq("to_before_estado", 32'(db_estado), 3);
    check_eq("to_before_perdeu", 32'(perdeu), 0);
    tick();
    check_eq("to_perdeu", 32'(perdeu), 1);
    check_eq("to_flag", 32'(db_timeout), 1);
    check_eq("to_estado", 32'(db_estado), 9);
    check_eq("to_rodada", 32'(db_rodada), 3);
    check_eq("to_pronto", 32'(pronto), 1);
    check_eq("to_ganhou", 32'(ganhou), 0);

    // Restart after a loss clears round and flags
    jogar = 1'b1;
    tick();
    jogar = 1'b0;
    check_eq("rs2_estado", 32'(db_estado), 1);
    check_eq("rs2_perdeu", 32'(perdeu), 0);
    tick();
    check_eq("rs2_rodada", 32'(db_rodada), 0);
    check_eq("rs2_estado_espera", 32'(db_estado), 3);
    check_eq("rs2_timeout", 32'(db_timeout), 0);

    // Wrong button at round 2, jogada 2
    play_round(0);
    play_round(1);
    press(4'b0001);
    press(4'b0010);
    botoes = 4'b0010;
    #1;
    check_eq("wr_echo_leds", 32'(leds), 32'b0010);
    tick();
    check_eq("wr_registra", 32'(db_estado), 4);
    tick();
    check_eq("wr_compara", 32'(db_estado), 5);
    tick();
    check_eq("wr_perdeu", 32'(perdeu), 1);
    check_eq("wr_estado", 32'(db_estado), 9);
    check_eq("wr_timeout", 32'(db_timeout), 0);
    check_eq("wr_rodada", 32'(db_rodada), 2);
    check_eq("wr_leds_off", 32'(leds), 0);
    botoes = 4'b0000;
    repeat (5) tick();

    // Multi-bit press at round 0
    restart(1'b0);
    press(4'b0011);
    check_eq("mb_perdeu", 32'(perdeu), 1);
    check_eq("mb_estado", 32'(db_estado), 9);

    // Show mode; modo is dropped after start to confirm it was latched
    restart(1'b1);
    check_eq("sh_estado_mostra", 32'(db_estado), 2);
    modo = 1'b0;
    wait_estado(4'd3, 40);
    botoes = 4'b0001;
    repeat (4) tick();
    for (int i = 0; i < 16; i++) begin
      check_eq("sh_leds", 32'(leds), (i < 4) ? 1 : (i < 8) ? 0 : (i < 12) ? 2 : 0);
      if (i == 0) botoes = 4'b0000;
      if (i == 6) botoes = 4'b0100;
      if (i == 9) begin
        botoes = 4'b0000;
        check_eq("sh_ignore_estado", 32'(db_estado), 2);
      end
      tick();
    end
    check_eq("sh_end_estado", 32'(db_estado), 3);
    check_eq("sh_end_perdeu", 32'(perdeu), 0);
    press(4'b0001);
    press(4'b0010);
    check_eq("sh_r2_estado", 32'(db_estado), 2);
    check_eq("sh_r2_rodada", 32'(db_rodada), 2);

    // Reset in the middle of MOSTRA, with jogar also high
    reset = 1'b1;
    jogar = 1'b1;
    tick();
    check_idle("rst_mostra");
    reset = 1'b0;
    jogar = 1'b0;
    tick();
    check_eq("rst_hold_estado", 32'(db_estado), 0);

    // Reset mid-round 5 in classic mode
    restart(1'b0);
    for (int r = 0; r < 5; r++) play_round(r);
    press(4'b0001);
    check_eq("r5_rodada", 32'(db_rodada), 5);
    reset = 1'b1;
    tick();
    check_idle("rst_r5");
    reset = 1'b0;

    // Lose, then jogar restarts cleanly
    restart(1'b0);
    press(4'b0100);
    check_eq("ls_perdeu", 32'(perdeu), 1);
    jogar = 1'b1;
    tick();
    jogar = 1'b0;
    check_eq("ls_rs_perdeu", 32'(perdeu), 0);
    check_eq("ls_rs_estado", 32'(db_estado), 1);
    tick();
    check_eq("ls_rs_rodada", 32'(db_rodada), 0);
    check_eq("ls_rs_espera", 32'(db_estado), 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
